muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the execute stage, directly downstream of the register bank.
- Consumes the two register read operands (A port, B port) and holds the architectural HI/LO result registers.
- Implements MULT, MULTU, DIV and DIVU, plus direct HI/LO writes (MTHI/MTLO).
- Pipeline control stalls on `busy` and reads HI/LO after `done`.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_if.sv | 33 +++
 rtl/muldiv_signfix.sv | 14 +
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths, op codes,
// FSM states and small op-decode helpers.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam int CNTW = $clog2(XLEN);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } opT;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FINISH = 2'b10
    } stateT;

    function automatic logic isSignedOp(input opT o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic isDivOp(input opT o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Bus between the execute-stage control and the multiply/divide unit.
//
// Handshake: start is accepted only on an edge where busy=0; busy stays high
// from the following cycle until the result cycle, in which done pulses for
// exactly one cycle and hi/lo already hold the new result. wrHi/wrLo act only
// when busy=0 and start=0 on the same edge.
interface muldiv_if;
    import muldiv_pkg::*;

    logic            start;
    opT              op;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic            wrHi;
    logic            wrLo;
    logic [XLEN-1:0] wrData;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    stateT           dbgState;

    modport master (
        output start, op, opA, opB, wrHi, wrLo, wrData,
        input  busy, done, hi, lo, dbgState
    );

    modport slave (
        input  start, op, opA, opB, wrHi, wrLo, wrData,
        output busy, done, hi, lo, dbgState
    );

endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore result signs.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    // The result is read as unsigned, so |most-negative| stays representable.
    assign result = negate ? (~value + 1'b1) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// One product/quotient bit per cycle; sign handling wraps an unsigned core.
module muldiv_unit
    import muldiv_pkg::*;
(
    input logic      clk,
    input logic      reset,
    muldiv_if.slave  bus
);

    stateT             state;
    logic [CNTW-1:0]   cnt;
    logic              busyReg;
    logic              doneReg;
    logic [XLEN-1:0]   hiReg;
    logic [XLEN-1:0]   loReg;

    logic              opIsDiv;
    logic              negRes;
    logic              negRem;
    logic              divZero;
    logic [XLEN-1:0]   origA;
    logic [XLEN-1:0]   operand;
    logic [2*XLEN-1:0] acc;

    // Operand conditioning at launch
    logic            startSigned;
    logic [XLEN-1:0] magA;
    logic [XLEN-1:0] magB;

    assign startSigned = isSignedOp(bus.op);

    muldiv_signfix #(.W(XLEN)) uAbsA (
        .value(bus.opA), .negate(startSigned && bus.opA[XLEN-1]), .result(magA)
    );
    muldiv_signfix #(.W(XLEN)) uAbsB (
        .value(bus.opB), .negate(startSigned && bus.opB[XLEN-1]), .result(magB)
    );

    // Shift-add multiply step: acc = {partial high, remaining multiplier bits}
    logic [XLEN:0]     mulSum;
    logic [2*XLEN-1:0] mulNext;

    assign mulSum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    assign mulNext = {mulSum, acc[XLEN-1:1]};

    // Restoring divide step: acc = {partial remainder, dividend/quotient}
    logic [XLEN:0]     divShift;
    logic              divGeq;
    logic [XLEN-1:0]   divSub;
    logic [XLEN-1:0]   divRem;
    logic [2*XLEN-1:0] divNext;

    assign divShift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign divGeq   = divShift >= {1'b0, operand};
    // When divGeq holds the true difference is below operand, so XLEN bits suffice.
    assign divSub   = divShift[XLEN-1:0] - operand;
    assign divRem   = divGeq ? divSub : divShift[XLEN-1:0];
    assign divNext  = {divRem, acc[XLEN-2:0], divGeq};

    logic [2*XLEN-1:0] stepNext;
    assign stepNext = opIsDiv ? divNext : mulNext;

    // Sign post-correction applied to the value the last step produces
    logic [2*XLEN-1:0] prodFixed;
    logic [XLEN-1:0]   quotFixed;
    logic [XLEN-1:0]   remFixed;

    muldiv_signfix #(.W(2*XLEN)) uFixProd (
        .value(stepNext), .negate(negRes), .result(prodFixed)
    );
    muldiv_signfix #(.W(XLEN)) uFixQuot (
        .value(stepNext[XLEN-1:0]), .negate(negRes), .result(quotFixed)
    );
    muldiv_signfix #(.W(XLEN)) uFixRem (
        .value(stepNext[2*XLEN-1:XLEN]), .negate(negRem), .result(remFixed)
    );

    logic [XLEN-1:0] hiNew;
    logic [XLEN-1:0] loNew;

    always_comb begin
        hiNew = prodFixed[2*XLEN-1:XLEN];
        loNew = prodFixed[XLEN-1:0];
        if (opIsDiv) begin
            if (divZero) begin
                hiNew = origA;
                loNew = '1;
            end else begin
                hiNew = remFixed;
                loNew = quotFixed;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
            opIsDiv <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            origA   <= '0;
            operand <= '0;
            acc     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    doneReg <= 1'b0;
                    if (bus.start) begin
                        opIsDiv <= isDivOp(bus.op);
                        negRes  <= startSigned && (bus.opA[XLEN-1] ^ bus.opB[XLEN-1]);
                        negRem  <= startSigned && bus.opA[XLEN-1];
                        divZero <= isDivOp(bus.op) && (bus.opB == '0);
                        origA   <= bus.opA;
                        operand <= isDivOp(bus.op) ? magB : magA;
                        acc     <= {{XLEN{1'b0}}, (isDivOp(bus.op) ? magA : magB)};
                        cnt     <= '0;
                        busyReg <= 1'b1;
                        state   <= RUN;
                    end else begin
                        if (bus.wrHi) hiReg <= bus.wrData;
                        if (bus.wrLo) loReg <= bus.wrData;
                    end
                end
                RUN: begin
                    acc <= stepNext;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNTW'(XLEN - 1)) begin
                        hiReg   <= hiNew;
                        loReg   <= loNew;
                        doneReg <= 1'b1;
                        state   <= FINISH;
                    end
                end
                FINISH: begin
                    doneReg <= 1'b0;
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busyReg <= 1'b0;
                    doneReg <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busyReg;
    assign bus.done     = doneReg;
    assign bus.hi       = hiReg;
    assign bus.lo       = loReg;
    assign bus.dbgState = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences
// and randomized operations against a plain-arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk;
    logic reset;
    muldiv_if bus();

    muldiv_unit dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatch = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        string       name;
    } vecT;

    vecT vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        nCompared++;
        if (act !== expv) begin
            nMismatch++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Reference: full-width integer arithmetic, returns {hi, lo}
    function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint          sa, sb, q, r, p;
        longint unsigned ua, ub, uq, ur, up;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = '0;
        case (op)
            2'b00: begin p = sa * sb; res = p; end
            2'b01: begin up = ua * ub; res = up; end
            2'b10: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // driver: call at a negedge; returns at the negedge after the start edge
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expv, input logic alsoWrLo,
                          output logic [31:0] prevHi, output logic [31:0] prevLo);
        prevHi = bus.hi;
        prevLo = bus.lo;
        exp_q.push_back(expv);
        bus.start = 1'b1;
        bus.op    = opT'(op);
        bus.opA   = a;
        bus.opB   = b;
        if (alsoWrLo) begin
            bus.wrLo   = 1'b1;
            bus.wrData = 32'h1111_1111;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.wrLo  = 1'b0;
    endtask

    // glitchKind: 0 none, 1 start pulse while busy, 2 wrHi pulse while busy
    task automatic waitResult(input string name, input int glitchKind, input int glitchAt,
                              input logic [31:0] prevHi, input logic [31:0] prevLo);
        int doneK;
        int doneCnt;
        int busyErr;
        int holdErr;
        logic [63:0] expv;
        doneK = -1;
        doneCnt = 0;
        busyErr = 0;
        holdErr = 0;
        for (int k = 1; k <= 34; k++) begin
            if (k > 1) @(negedge clk);
            if (glitchKind == 1 && k == glitchAt) begin
                bus.start = 1'b1;
                bus.op    = OP_MULTU;
                bus.opA   = 32'd1;
                bus.opB   = 32'd1;
            end
            if (glitchKind == 2 && k == glitchAt) begin
                bus.wrHi   = 1'b1;
                bus.wrData = 32'hDEAD_BEEF;
            end
            if (k == glitchAt + 1) begin
                bus.start = 1'b0;
                bus.wrHi  = 1'b0;
            end
            if (bus.busy !== (k <= 33)) busyErr++;
            if (bus.done === 1'b1) begin
                doneCnt++;
                doneK = k;
            end
            if (k < 33 && (bus.hi !== prevHi || bus.lo !== prevLo)) holdErr++;
            if (k == 33) begin
                if (exp_q.size() == 0) begin
                    check({name, "_queue"}, 64'd0, 64'd1);
                end else begin
                    expv = exp_q.pop_front();
                    check({name, "_result"}, {bus.hi, bus.lo}, expv);
                end
            end
        end
        check({name, "_done_cycle"}, 64'(doneK), 64'd33);
        check({name, "_done_pulses"}, 64'(doneCnt), 64'd1);
        check({name, "_busy_profile"}, 64'(busyErr), 64'd0);
        check({name, "_hilo_hold"}, 64'(holdErr), 64'd0);
    endtask

    task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] expv,
                         input int glitchKind, input int glitchAt, input logic alsoWrLo);
        logic [31:0] ph, pl;
        launch(op, a, b, expv, alsoWrLo, ph, pl);
        waitResult(name, glitchKind, glitchAt, ph, pl);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ph, pl;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          doneSeen;
        int          busySeen;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7"};
        vecs[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minmin"};
        vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2"};
        vecs[4] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        "divu_100_7"};
        vecs[5] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_7_m2"};
        vecs[6] = '{2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, "div_by_zero"};
        vecs[7] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_overflow"};

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = OP_MULT;
        bus.opA    = '0;
        bus.opB    = '0;
        bus.wrHi   = 1'b0;
        bus.wrLo   = 1'b0;
        bus.wrData = '0;
        repeat (3) @(negedge clk);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_state", 64'(bus.dbgState), 64'(IDLE));
        reset = 1'b0;

        // direct HI/LO writes in IDLE
        bus.wrHi = 1'b1; bus.wrData = 32'h1234_5678;
        @(negedge clk);
        bus.wrHi = 1'b0;
        check("mthi_hi", 64'(bus.hi), 64'h1234_5678);
        check("mthi_lo", 64'(bus.lo), 64'd0);
        bus.wrLo = 1'b1; bus.wrData = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.wrLo = 1'b0;
        check("mtlo_hi", 64'(bus.hi), 64'h1234_5678);
        check("mtlo_lo", 64'(bus.lo), 64'h9ABC_DEF0);
        bus.wrHi = 1'b1; bus.wrLo = 1'b1; bus.wrData = 32'h0F0F_0F0F;
        @(negedge clk);
        bus.wrHi = 1'b0; bus.wrLo = 1'b0;
        check("mthilo_both", {bus.hi, bus.lo}, 64'h0F0F_0F0F_0F0F_0F0F);

        // directed vectors, launched back to back
        for (int i = 0; i < 8; i++) begin
            runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                  {vecs[i].expHi, vecs[i].expLo}, 0, 0, 1'b0);
        end

        runOp("start_while_busy", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 1, 5, 1'b0);
        runOp("wrhi_while_busy", 2'b01, 32'd6, 32'd7, {32'd0, 32'd42}, 2, 12, 1'b0);
        runOp("wrlo_with_start", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pickOperand();
            rb  = pickOperand();
            runOp($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, refModel(rop, ra, rb), 0, 0, 1'b0);
        end

        // reset aborts a running operation
        launch(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, ph, pl);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        doneSeen = 0;
        busySeen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneSeen++;
            if (bus.busy === 1'b1) busySeen++;
        end
        check("abort_no_done", 64'(doneSeen), 64'd0);
        check("abort_stays_idle", 64'(busySeen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
